// File: rtl/closest_block_hit_tracker.sv
// Tracks the nearest accepted ray/block hit across a group of intersection beats
// and emits one registered closest-hit record, one cycle after the group's last beat.
module closest_block_hit_tracker #(
    parameter int IDX_WIDTH         = 8,
    parameter bit REJECT_NEGATIVE_T = 1'b1
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 valid_in,
    input  logic                 intersects_in,
    input  logic [31:0]          t_in,
    input  logic [IDX_WIDTH-1:0] block_idx_in,
    input  logic                 last_in,
    output logic                 valid_out,
    output logic                 hit_out,
    output logic [31:0]          t_out,
    output logic [IDX_WIDTH-1:0] block_idx_out,
    output logic [IDX_WIDTH:0]   hit_count_out
);

    localparam int CNT_W = IDX_WIDTH + 1;

    typedef enum logic {
        EMPTY,
        HAVE_HIT
    } state_t;

    state_t               state_q, state_d;
    logic [31:0]          best_t_q, best_t_d;
    logic [IDX_WIDTH-1:0] best_idx_q, best_idx_d;
    logic [CNT_W-1:0]     count_q, count_d;

    logic                 out_valid_d, out_hit_d;
    logic [31:0]          out_t_d;
    logic [IDX_WIDTH-1:0] out_idx_d;
    logic [CNT_W-1:0]     out_cnt_d;

    logic                 is_nan, is_neg, accept, take;
    state_t               beat_state;
    logic [31:0]          beat_t;
    logic [IDX_WIDTH-1:0] beat_idx;
    logic [CNT_W-1:0]     beat_cnt;

    // Strict a < b on IEEE-754 singles, NaN excluded upstream; +0 and -0 compare equal.
    function automatic logic f32_less(input logic [31:0] a, input logic [31:0] b);
        logic both_zero;
        both_zero = (a[30:0] == 31'd0) && (b[30:0] == 31'd0);
        case ({a[31], b[31]})
            2'b00:   return a[30:0] < b[30:0];
            2'b11:   return a[30:0] > b[30:0];
            2'b10:   return !both_zero;
            default: return 1'b0;
        endcase
    endfunction

    // NOTE: every always_comb output gets a default first so no path leaves a latch.
    always_comb begin
        is_nan = (t_in[30:23] == 8'hFF) && (t_in[22:0] != 23'd0);
        is_neg = t_in[31] && (t_in[30:0] != 31'd0);
        accept = valid_in && intersects_in && !is_nan && !(REJECT_NEGATIVE_T && is_neg);
        // Strict compare keeps the earlier block on ties.
        take   = accept && ((state_q == EMPTY) || f32_less(t_in, best_t_q));

        beat_state = (accept || state_q == HAVE_HIT) ? HAVE_HIT : EMPTY;
        beat_t     = take ? t_in : best_t_q;
        beat_idx   = take ? block_idx_in : best_idx_q;
        beat_cnt   = (accept && !(&count_q)) ? count_q + CNT_W'(1) : count_q;

        state_d    = beat_state;
        best_t_d   = beat_t;
        best_idx_d = beat_idx;
        count_d    = beat_cnt;

        out_valid_d = 1'b0;
        out_hit_d   = hit_out;
        out_t_d     = t_out;
        out_idx_d   = block_idx_out;
        out_cnt_d   = hit_count_out;

        if (valid_in && last_in) begin
            out_valid_d = 1'b1;
            out_hit_d   = (beat_state == HAVE_HIT);
            out_t_d     = beat_t;
            out_idx_d   = beat_idx;
            out_cnt_d   = beat_cnt;
            // Clearing at the same edge lets the next beat open a new group with no bubble.
            state_d     = EMPTY;
            best_t_d    = 32'd0;
            best_idx_d  = '0;
            count_d     = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q       <= EMPTY;
            best_t_q      <= 32'd0;
            best_idx_q    <= '0;
            count_q       <= '0;
            valid_out     <= 1'b0;
            hit_out       <= 1'b0;
            t_out         <= 32'd0;
            block_idx_out <= '0;
            hit_count_out <= '0;
        end else begin
            state_q       <= state_d;
            best_t_q      <= best_t_d;
            best_idx_q    <= best_idx_d;
            count_q       <= count_d;
            valid_out     <= out_valid_d;
            hit_out       <= out_hit_d;
            t_out         <= out_t_d;
            block_idx_out <= out_idx_d;
            hit_count_out <= out_cnt_d;
        end
    end

endmodule

// File: tb/tb_closest_block_hit_tracker.sv
// Scoreboard bench: directed groups push expected records; a monitor checks each valid_out pulse.
module tb_closest_block_hit_tracker;

    localparam int IDX_WIDTH = 8;

    localparam logic [31:0] T_100  = 32'h42C8_0000;
    localparam logic [31:0] T_50   = 32'h4248_0000;
    localparam logic [31:0] T_200  = 32'h4348_0000;
    localparam logic [31:0] T_M10  = 32'hC120_0000;
    localparam logic [31:0] T_NAN  = 32'h7FC0_0000;
    localparam logic [31:0] T_PZ   = 32'h0000_0000;
    localparam logic [31:0] T_NZ   = 32'h8000_0000;
    localparam logic [31:0] T_PINF = 32'h7F80_0000;

    logic                 clk_in = 1'b0;
    logic                 rst_in = 1'b1;
    logic                 valid_in = 1'b0;
    logic                 intersects_in = 1'b0;
    logic [31:0]          t_in = 32'd0;
    logic [IDX_WIDTH-1:0] block_idx_in = '0;
    logic                 last_in = 1'b0;
    logic                 valid_out;
    logic                 hit_out;
    logic [31:0]          t_out;
    logic [IDX_WIDTH-1:0] block_idx_out;
    logic [IDX_WIDTH:0]   hit_count_out;

    closest_block_hit_tracker #(
        .IDX_WIDTH(IDX_WIDTH),
        .REJECT_NEGATIVE_T(1'b1)
    ) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .valid_in(valid_in),
        .intersects_in(intersects_in),
        .t_in(t_in),
        .block_idx_in(block_idx_in),
        .last_in(last_in),
        .valid_out(valid_out),
        .hit_out(hit_out),
        .t_out(t_out),
        .block_idx_out(block_idx_out),
        .hit_count_out(hit_count_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic                 hit;
        logic [31:0]          t;
        logic [IDX_WIDTH-1:0] idx;
        logic [IDX_WIDTH:0]   cnt;
        int                   cyc;
        string                tag;
    } rec_t;

    rec_t exp_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Drive one cycle of input; sampled by the DUT at the next rising edge.
    task automatic beat(input logic v, input logic hit, input logic [31:0] t,
                        input logic [IDX_WIDTH-1:0] idx, input logic last);
        @(posedge clk_in);
        #1;
        valid_in      = v;
        intersects_in = hit;
        t_in          = t;
        block_idx_in  = idx;
        last_in       = last;
    endtask

    // Queue the record expected one cycle after the last beat driven now.
    task automatic expect_rec(input string tag, input logic hit, input logic [31:0] t,
                              input logic [IDX_WIDTH-1:0] idx, input logic [IDX_WIDTH:0] cnt);
        rec_t r;
        r.hit = hit; r.t = t; r.idx = idx; r.cnt = cnt; r.cyc = cyc + 1; r.tag = tag;
        exp_q.push_back(r);
    endtask

    task automatic idle();
        beat(1'b0, 1'b0, 32'd0, '0, 1'b0);
    endtask

    always @(negedge clk_in) begin
        if (valid_out === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_valid_out", {31'd0, valid_out}, 32'd0);
            end else begin
                rec_t r;
                r = exp_q.pop_front();
                check({r.tag, "_latency"}, cyc, r.cyc);
                check({r.tag, "_hit"}, {31'd0, hit_out}, {31'd0, r.hit});
                check({r.tag, "_t"}, t_out, r.t);
                check({r.tag, "_idx"}, {24'd0, block_idx_out}, {24'd0, r.idx});
                check({r.tag, "_cnt"}, {23'd0, hit_count_out}, {23'd0, r.cnt});
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        @(negedge clk_in);
        check({tag, "_valid"}, {31'd0, valid_out}, 32'd0);
        check({tag, "_hit"}, {31'd0, hit_out}, 32'd0);
        check({tag, "_t"}, t_out, 32'd0);
        check({tag, "_idx"}, {24'd0, block_idx_out}, 32'd0);
        check({tag, "_cnt"}, {23'd0, hit_count_out}, 32'd0);
    endtask

    initial begin
        int budget;
        repeat (2) @(posedge clk_in);
        #1 rst_in = 1'b0;
        check_reset_outputs("reset");

        // Nearest of three hits, arriving mid-group.
        beat(1, 1, T_100, 8'd0, 0);
        beat(1, 1, T_50,  8'd1, 0);
        beat(1, 1, T_200, 8'd2, 1);
        expect_rec("three_hits", 1'b1, T_50, 8'd1, 9'd3);
        idle();

        // All-miss group.
        for (int i = 0; i < 4; i++) begin
            beat(1, 0, 32'd0, IDX_WIDTH'(i), (i == 3));
        end
        expect_rec("all_miss", 1'b0, 32'd0, 8'd0, 9'd0);
        idle();

        // Negative t and NaN rejected; tie keeps the earlier block.
        beat(1, 1, T_M10, 8'd5, 0);
        beat(1, 1, T_NAN, 8'd6, 0);
        beat(1, 1, T_100, 8'd7, 0);
        beat(1, 1, T_100, 8'd8, 1);
        expect_rec("neg_nan_tie", 1'b1, T_100, 8'd7, 9'd2);

        // Back-to-back single-beat groups.
        beat(1, 1, T_50, 8'd3, 1);
        expect_rec("b2b_a", 1'b1, T_50, 8'd3, 9'd1);
        beat(1, 1, T_200, 8'd4, 1);
        expect_rec("b2b_b", 1'b1, T_200, 8'd4, 9'd1);

        // valid_in gaps carrying junk must not disturb the group.
        beat(1, 1, T_100, 8'd0, 0);
        beat(0, 1, 32'h3F80_0000, 8'd77, 1);
        beat(1, 1, T_50,  8'd1, 0);
        beat(0, 1, 32'h0000_0001, 8'd88, 1);
        beat(0, 1, T_M10, 8'd99, 0);
        beat(1, 1, T_200, 8'd2, 1);
        expect_rec("gaps", 1'b1, T_50, 8'd1, 9'd3);
        idle();

        // Signed zeros compare equal (tie keeps first); -0.0 is accepted.
        beat(1, 1, T_PZ, 8'd10, 0);
        beat(1, 1, T_NZ, 8'd11, 1);
        expect_rec("zeros", 1'b1, T_PZ, 8'd10, 9'd2);

        // +Inf is a valid hit, and a later smaller hit replaces it.
        beat(1, 1, T_PINF, 8'd12, 1);
        expect_rec("inf", 1'b1, T_PINF, 8'd12, 9'd1);
        beat(1, 1, T_PINF, 8'd13, 0);
        beat(1, 1, T_200,  8'd14, 1);
        expect_rec("inf_replaced", 1'b1, T_200, 8'd14, 9'd2);
        idle();

        // Reset mid-group discards it; the next group starts clean.
        beat(1, 1, T_50, 8'd20, 0);
        beat(1, 1, T_100, 8'd21, 0);
        @(posedge clk_in);
        #1;
        valid_in = 1'b0;
        rst_in   = 1'b1;
        @(posedge clk_in);
        #1 rst_in = 1'b0;
        check_reset_outputs("mid_reset");
        beat(1, 1, T_200, 8'd9, 1);
        expect_rec("after_reset", 1'b1, T_200, 8'd9, 9'd1);
        idle();

        budget = 0;
        while (exp_q.size() != 0 && budget < 20) begin
            @(posedge clk_in);
            budget++;
        end
        repeat (3) @(posedge clk_in);
        check("pending_records", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
